fp_mul_mantissa_seq: RTL and testbench

// - Sequential 24x24 unsigned mantissa multiplier for the FP32 multiply path.
// - Sits directly downstream of the mantissa/exponent/sign prepare stage.
// - Consumes its two normalized mantissas, biased exponent sum and result sign.
// - Produces the exact 48-bit product for the post-multiply normalize/round stage.
// - Uses an iterative shift-add datapath with valid/ready handshakes on both sides.

---
 rtl/fp_mul_mantissa_seq.sv | 145 ++++++++++++++
 tb/tb_fp_mul_mantissa_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_mantissa_seq.sv
// rtl/fp_mul_mantissa_seq.sv - sequential shift-add 24x24 mantissa multiplier for the FP32 multiply path
//
// Purpose:
//   Takes the two normalized mantissas, the biased exponent sum and the result
//   sign from the prepare stage, and multiplies the mantissas with an iterative
//   shift-add datapath. BPC multiplier bits are retired per cycle. The result
//   is the exact 2*MAN_W-bit product, handed to the normalize/round stage.
//   The exponent and sign are captured at accept and passed through unchanged.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         upstream operand handshake (in_ready = IDLE)
//   mul1_mantissa_normalized    multiplicand  [MAN_W]
//   mul2_mantissa_normalized    multiplier    [MAN_W]
//   current_exponent            exponent from the prepare stage [EXP_W]
//   result_sign                 sign from the prepare stage
//   out_valid / out_ready       downstream product handshake (out_valid = DONE)
//   product                     registered mul1*mul2 [2*MAN_W]
//   out_exponent, out_sign      registered pass-through of exponent/sign
//   busy                        operation in flight (state != IDLE)
//
// Configuration:
//   FP_MUL_ZERO_SKIP_EN  when defined, a zero operand finishes after a single
//                        RUN cycle with product 0 instead of N iterations.

module fp_mul_mantissa_seq #(
  parameter int MAN_W = 24,
  parameter int EXP_W = 8,
  parameter int BPC   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MAN_W-1:0]   mul1_mantissa_normalized,
  input  logic [MAN_W-1:0]   mul2_mantissa_normalized,
  input  logic [EXP_W-1:0]   current_exponent,
  input  logic               result_sign,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*MAN_W-1:0] product,
  output logic [EXP_W-1:0]   out_exponent,
  output logic               out_sign,
  output logic               busy
);

  localparam int N     = MAN_W / BPC;
  localparam int CNT_W = (N > 2) ? $clog2(N) : 1;
  localparam int P_W   = 2 * MAN_W;

  if (((MAN_W % BPC) != 0) ||
      !((BPC == 1) || (BPC == 2) || (BPC == 3) || (BPC == 4) || (BPC == 6) || (BPC == 8)))
  begin : g_bad_bpc
    $error("fp_mul_mantissa_seq: BPC must be one of 1,2,3,4,6,8 and divide MAN_W");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [P_W-1:0]     a_sh_q;   // multiplicand, pre-shifted to the current digit weight
  logic [MAN_W-1:0]   b_q;      // remaining multiplier digits, LSB digit is next
  logic [P_W-1:0]     acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [EXP_W-1:0]   exp_q;
  logic               sign_q;
  logic [P_W-1:0]     partial;
  logic               last_iter;
  logic               zero_skip;

  // Shifting the multiplicand one digit per cycle gives (digit * A) << (cnt*BPC)
  // without a variable barrel shifter.
  assign partial   = a_sh_q * {{(P_W-BPC){1'b0}}, b_q[BPC-1:0]};
  assign last_iter = (cnt_q == CNT_W'(N - 1));

`ifdef FP_MUL_ZERO_SKIP_EN
  // The first RUN cycle still sees the operands as captured, so a zero there
  // means a zero input; every partial is then zero and acc already holds 0.
  assign zero_skip = (cnt_q == '0) && ((a_sh_q == '0) || (b_q == '0));
`else
  assign zero_skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)                state_d = RUN;
      RUN:     if (last_iter || zero_skip)  state_d = DONE;
      DONE:    if (out_ready)               state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      exp_q  <= '0;
      sign_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q <= {{MAN_W{1'b0}}, mul1_mantissa_normalized};
            b_q    <= mul2_mantissa_normalized;
            exp_q  <= current_exponent;
            sign_q <= result_sign;
            acc_q  <= '0;
            cnt_q  <= '0;
          end
        end
        RUN: begin
          acc_q  <= acc_q + partial;
          a_sh_q <= a_sh_q << BPC;
          b_q    <= b_q >> BPC;
          cnt_q  <= cnt_q + CNT_W'(1);
        end
        default: begin
          // DONE: hold everything so the product is stable under backpressure.
        end
      endcase
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign product      = acc_q;
  assign out_exponent = exp_q;
  assign out_sign     = sign_q;

endmodule

// File: tb/tb_fp_mul_mantissa_seq.sv
// tb/tb_fp_mul_mantissa_seq.sv - directed and random checks of fp_mul_mantissa_seq at BPC=1 and BPC=4
module tb_fp_mul_mantissa_seq;

  localparam int N1 = 24;
  localparam int N4 = 6;
`ifdef FP_MUL_ZERO_SKIP_EN
  localparam int Z1 = 1;
  localparam int Z4 = 1;
`else
  localparam int Z1 = N1;
  localparam int Z4 = N4;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_v  [2];
  logic        in_ready_v  [2];
  logic [23:0] mul1_v      [2];
  logic [23:0] mul2_v      [2];
  logic [7:0]  cexp_v      [2];
  logic        rsign_v     [2];
  logic        out_valid_v [2];
  logic        out_ready_v [2];
  logic [47:0] prod_v      [2];
  logic [7:0]  oexp_v      [2];
  logic        osign_v     [2];
  logic        busy_v      [2];

  int total_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  fp_mul_mantissa_seq #(.MAN_W(24), .EXP_W(8), .BPC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .mul1_mantissa_normalized(mul1_v[0]), .mul2_mantissa_normalized(mul2_v[0]),
    .current_exponent(cexp_v[0]), .result_sign(rsign_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .product(prod_v[0]), .out_exponent(oexp_v[0]), .out_sign(osign_v[0]),
    .busy(busy_v[0])
  );

  fp_mul_mantissa_seq #(.MAN_W(24), .EXP_W(8), .BPC(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .mul1_mantissa_normalized(mul1_v[1]), .mul2_mantissa_normalized(mul2_v[1]),
    .current_exponent(cexp_v[1]), .result_sign(rsign_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .product(prod_v[1]), .out_exponent(oexp_v[1]), .out_sign(osign_v[1]),
    .busy(busy_v[1])
  );

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [7:0]  e;
    logic        s;
    logic [47:0] p;
    int          lat;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
  endtask

  task automatic start_op(input int k, input logic [23:0] a, input logic [23:0] b,
                          input logic [7:0] e, input logic s, input string nm);
    chk({nm, "_in_ready"}, 64'(in_ready_v[k]), 64'd1);
    mul1_v[k]     = a;
    mul2_v[k]     = b;
    cexp_v[k]     = e;
    rsign_v[k]    = s;
    in_valid_v[k] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_v[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int exp_lat, input logic [47:0] p,
                           input logic [7:0] e, input logic s, input string nm);
    int lat = 0;
    while (!out_valid_v[k] && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, "_product"}, 64'(prod_v[k]), 64'(p));
    chk({nm, "_exponent"}, 64'(oexp_v[k]), 64'(e));
    chk({nm, "_sign"}, 64'(osign_v[k]), 64'(s));
  endtask

  task automatic finish_op(input int k, input bit rnd, input logic [47:0] p, input string nm);
    int  w = 0;
    logic r;
    forever begin
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready_v[k] = r;
      @(posedge clk);
      #1;
      w++;
      if (r) break;
      chk({nm, "_stall_product"}, 64'(prod_v[k]), 64'(p));
      if (w >= 64) begin
        chk({nm, "_handshake_timeout"}, 64'd0, 64'd1);
        break;
      end
    end
    out_ready_v[k] = 1'b0;
    chk({nm, "_out_valid_after_hs"}, 64'(out_valid_v[k]), 64'd0);
    chk({nm, "_in_ready_after_hs"}, 64'(in_ready_v[k]), 64'd1);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      in_valid_v[k] = 1'b0; out_ready_v[k] = 1'b0;
      mul1_v[k] = '0; mul2_v[k] = '0; cexp_v[k] = '0; rsign_v[k] = 1'b0;
    end
    vecs[0] = '{24'h800000, 24'h800000, 8'h7F, 1'b0, 48'h400000000000, N1};
    vecs[1] = '{24'hFFFFFF, 24'hFFFFFF, 8'h81, 1'b1, 48'hFFFFFE000001, N1};
    vecs[2] = '{24'hC00000, 24'hA00000, 8'h80, 1'b0, 48'h780000000000, N1};
    vecs[3] = '{24'h000000, 24'h800000, 8'h10, 1'b1, 48'h000000000000, Z1};
    vecs[4] = '{24'h800001, 24'h800000, 8'h7E, 1'b0, 48'h400000800000, N1};
    vecs[5] = '{24'h000001, 24'h000001, 8'h01, 1'b1, 48'h000000000001, N1};
    vecs[6] = '{24'hABCDEF, 24'h000002, 8'hFE, 1'b0, 48'h000001579BDE, N1};
    vecs[7] = '{24'h123456, 24'h000000, 8'h55, 1'b1, 48'h000000000000, Z1};

    rst_n = 1'b0;
    #23;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_out_valid", 64'(out_valid_v[k]), 64'd0);
      chk("reset_busy", 64'(busy_v[k]), 64'd0);
      chk("reset_in_ready", 64'(in_ready_v[k]), 64'd1);
      chk("reset_product", 64'(prod_v[k]), 64'd0);
      chk("reset_exponent", 64'(oexp_v[k]), 64'd0);
      chk("reset_sign", 64'(osign_v[k]), 64'd0);
    end

    // Directed vectors at BPC=1.
    for (int i = 0; i < 8; i++) begin
      start_op(0, vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].s, $sformatf("vec%0d", i));
      wait_done(0, vecs[i].lat, vecs[i].p, vecs[i].e, vecs[i].s, $sformatf("vec%0d", i));
      finish_op(0, 1'b0, vecs[i].p, $sformatf("vec%0d", i));
    end

    // Backpressure: 7 stall cycles, with a competing request that must be ignored.
    start_op(0, 24'hFFFFFF, 24'hFFFFFF, 8'h9A, 1'b1, "bp");
    wait_done(0, N1, 48'hFFFFFE000001, 8'h9A, 1'b1, "bp");
    mul1_v[0] = 24'h800000; mul2_v[0] = 24'h800000; cexp_v[0] = 8'h11; rsign_v[0] = 1'b0;
    in_valid_v[0] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk);
      #1;
      chk("bp_product", 64'(prod_v[0]), 64'hFFFFFE000001);
      chk("bp_exponent", 64'(oexp_v[0]), 64'h9A);
      chk("bp_sign", 64'(osign_v[0]), 64'd1);
      chk("bp_in_ready", 64'(in_ready_v[0]), 64'd0);
      chk("bp_out_valid", 64'(out_valid_v[0]), 64'd1);
    end
    in_valid_v[0] = 1'b0;
    out_ready_v[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_v[0] = 1'b0;
    chk("bp_out_valid_after_hs", 64'(out_valid_v[0]), 64'd0);
    chk("bp_in_ready_after_hs", 64'(in_ready_v[0]), 64'd1);
    @(posedge clk);
    #1;
    chk("bp_single_handshake", 64'(busy_v[0]), 64'd0);

    // Reset in the middle of RUN.
    start_op(0, 24'h123456, 24'h654321, 8'h44, 1'b1, "rst");
    repeat (10) @(posedge clk);
    #1;
    chk("rst_busy_before", 64'(busy_v[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid_v[0]), 64'd0);
    chk("rst_busy", 64'(busy_v[0]), 64'd0);
    chk("rst_product", 64'(prod_v[0]), 64'd0);
    chk("rst_exponent", 64'(oexp_v[0]), 64'd0);
    chk("rst_in_ready", 64'(in_ready_v[0]), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_op(0, 24'hC00000, 24'hA00000, 8'h82, 1'b0, "post_rst");
    wait_done(0, N1, 48'h780000000000, 8'h82, 1'b0, "post_rst");
    finish_op(0, 1'b0, 48'h780000000000, "post_rst");

    // BPC=4: random operands against a plain multiply, random backpressure.
    for (int i = 0; i < 200; i++) begin
      logic [23:0] a, b;
      logic [7:0]  e;
      logic        s;
      logic [47:0] p;
      a = 24'($urandom);
      b = 24'($urandom);
      if (i == 5) a = 24'h0;
      if (i == 9) b = 24'h0;
      e = 8'($urandom);
      s = 1'($urandom);
      p = {24'h0, a} * {24'h0, b};
      start_op(1, a, b, e, s, "rnd");
      wait_done(1, ((a == 24'h0) || (b == 24'h0)) ? Z4 : N4, p, e, s, "rnd");
      finish_op(1, 1'b1, p, "rnd");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
